conv_1x1_mac_acc: RTL and testbench

- Parametrised 1x1 convolution engine, fixed-point (signed Q format).
- Holds the full CHANNEL_NUM_OUT x CHANNEL_NUM_IN weight set on chip.
- For each spatial location, buffers CHANNEL_NUM_IN input pixels, then streams out CHANNEL_NUM_OUT dot products.
- Each dot product is rounded, saturated and optionally ReLU'd. Replaces per-beat multiply-only 1x1 tops in the conv_1x1 layer chain.

---
 rtl/conv_1x1_mac_acc.sv | 184 ++++++++++++++++++
 tb/tb_conv_1x1_mac_acc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_mac_acc.sv
// 1x1 convolution: on-chip weight set, per-location pixel buffer, one MAC per cycle, rounded/saturated outputs.
// Latency: channel k out 3 cycles after its last issue; ready_in low during COMPUTE, outputs have no backpressure.
module conv_1x1_mac_acc #(
  parameter int DATA_WIDTH      = 16,
  parameter int FRAC_BITS       = 8,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 512,
  parameter int IMAGE_WIDTH     = 16,
  parameter int IMAGE_HEIGHT    = 16,
  parameter int RELU_EN         = 0,
  localparam int COW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  ready_in,
  input  logic                  valid_weight_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  input  logic                  weight_reload,
  output logic                  weights_ready,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic [COW-1:0]        ch_out_idx,
  output logic                  frame_done
);

  localparam int NW   = CHANNEL_NUM_OUT * CHANNEL_NUM_IN;
  localparam int WAW  = $clog2(NW);
  localparam int WCW  = $clog2(NW + 1);
  localparam int CIW  = $clog2(CHANNEL_NUM_IN);
  localparam int NLOC = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int LW   = (NLOC > 1) ? $clog2(NLOC) : 1;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int ACCW = PW + CIW;

  localparam logic [CIW-1:0] CI_LAST  = CIW'(CHANNEL_NUM_IN - 1);
  localparam logic [COW-1:0] CO_LAST  = COW'(CHANNEL_NUM_OUT - 1);
  localparam logic [WCW-1:0] W_LAST   = WCW'(NW - 1);
  localparam logic [LW-1:0]  LOC_LAST = LW'(NLOC - 1);
  localparam logic signed [ACCW-1:0] RND     = {{(ACCW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {WLOAD, FILL, COMPUTE} state_t;
  state_t state_q, state_d;

  logic [WCW-1:0] wcnt;
  logic [CIW-1:0] pcnt, ci;
  logic [COW-1:0] ck;
  logic [WAW-1:0] waddr;
  logic [LW-1:0]  loc;

  logic [DATA_WIDTH-1:0] wmem [NW];
  logic [DATA_WIDTH-1:0] pbuf [CHANNEL_NUM_IN];

  logic                  s1_vld, s1_first, s1_last, s2_vld, s2_first, s2_last;
  logic [COW-1:0]        s1_k, s2_k;
  logic [DATA_WIDTH-1:0] w_q, p_q;
  logic signed [PW-1:0]  prod_q;
  logic signed [ACCW-1:0] acc_q, prod_ext, sum, rnd, shifted;
  logic signed [DATA_WIDTH-1:0] res;

  logic w_acc, p_acc, issue, last_issue, reload_ok;

  assign ready_in   = (state_q == FILL) && weights_ready;
  assign w_acc      = (state_q == WLOAD) && valid_weight_in && !weight_reload;
  assign p_acc      = valid_in && ready_in;
  assign issue      = (state_q == COMPUTE);
  assign last_issue = issue && (ci == CI_LAST) && (ck == CO_LAST);
  // Reload only when no location is partially buffered and nothing is in flight.
  assign reload_ok  = weight_reload && ((state_q == WLOAD) ||
                      ((state_q == FILL) && (pcnt == '0) && !s1_vld && !s2_vld));

  always_comb begin
    state_d = state_q;
    case (state_q)
      WLOAD:   if (w_acc && (wcnt == W_LAST)) state_d = FILL;
      FILL:    if (p_acc && (pcnt == CI_LAST)) state_d = COMPUTE;
      COMPUTE: if (last_issue) state_d = FILL;
      default: state_d = WLOAD;
    endcase
    if (reload_ok) state_d = WLOAD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= WLOAD;
      wcnt          <= '0;
      weights_ready <= 1'b0;
      pcnt          <= '0;
      ci            <= '0;
      ck            <= '0;
      waddr         <= '0;
    end else begin
      state_q <= state_d;
      if (reload_ok) begin
        wcnt          <= '0;
        weights_ready <= 1'b0;
        pcnt          <= '0;
      end else begin
        if (w_acc) begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == W_LAST) weights_ready <= 1'b1;
        end
        if (p_acc) pcnt <= (pcnt == CI_LAST) ? '0 : pcnt + 1'b1;
      end
      if (issue) begin
        waddr <= last_issue ? '0 : waddr + 1'b1;
        if (ci == CI_LAST) begin
          ci <= '0;
          ck <= (ck == CO_LAST) ? '0 : ck + 1'b1;
        end else begin
          ci <= ci + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) wmem[wcnt[WAW-1:0]] <= weight_in;
    if (p_acc) pbuf[pcnt] <= pxl_in;
    w_q    <= wmem[waddr];
    p_q    <= pbuf[ci];
    prod_q <= $signed({{DATA_WIDTH{w_q[DATA_WIDTH-1]}}, w_q}) *
              $signed({{DATA_WIDTH{p_q[DATA_WIDTH-1]}}, p_q});
    if (s2_vld) acc_q <= sum;
  end

  always_comb begin
    prod_ext = {{CIW{prod_q[PW-1]}}, prod_q};
    sum      = s2_first ? prod_ext : acc_q + prod_ext;
    rnd      = sum + RND;
    shifted  = rnd >>> FRAC_BITS;
    if (shifted > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
    else                        res = shifted[DATA_WIDTH-1:0];
    if ((RELU_EN != 0) && res[DATA_WIDTH-1]) res = '0;
  end

  // Output register takes the final sum directly so it lands one cycle after the product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld     <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_k       <= '0;
      s2_vld     <= 1'b0;
      s2_first   <= 1'b0;
      s2_last    <= 1'b0;
      s2_k       <= '0;
      pxl_out    <= '0;
      ch_out_idx <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      loc        <= '0;
    end else begin
      s1_vld     <= issue;
      s1_first   <= (ci == '0);
      s1_last    <= (ci == CI_LAST);
      s1_k       <= ck;
      s2_vld     <= s1_vld;
      s2_first   <= s1_first;
      s2_last    <= s1_last;
      s2_k       <= s1_k;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (s2_vld && s2_last) begin
        valid_out  <= 1'b1;
        pxl_out    <= res;
        ch_out_idx <= s2_k;
        if (s2_k == CO_LAST) begin
          if (loc == LOC_LAST) begin
            loc        <= '0;
            frame_done <= 1'b1;
          end else begin
            loc <= loc + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_1x1_mac_acc.sv
// Directed bench for conv_1x1_mac_acc (CI=4, CO=2, 2x2 frame); plain and ReLU instances share stimulus.
module tb_conv_1x1_mac_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, valid_weight_in, weight_reload;
  logic [15:0] pxl_in, weight_in;
  logic        ready_in, weights_ready, valid_out, frame_done;
  logic [15:0] pxl_out;
  logic [0:0]  ch_out_idx;
  logic        r_ready_in, r_weights_ready, r_valid_out, r_frame_done;
  logic [15:0] r_pxl_out;
  logic [0:0]  r_ch_out_idx;

  always #5 clk = ~clk;

  conv_1x1_mac_acc #(.DATA_WIDTH(16), .FRAC_BITS(8), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
                     .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .RELU_EN(0)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .ready_in(ready_in),
    .valid_weight_in(valid_weight_in), .weight_in(weight_in), .weight_reload(weight_reload),
    .weights_ready(weights_ready), .pxl_out(pxl_out), .valid_out(valid_out),
    .ch_out_idx(ch_out_idx), .frame_done(frame_done));

  conv_1x1_mac_acc #(.DATA_WIDTH(16), .FRAC_BITS(8), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
                     .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .RELU_EN(1)) dut_relu (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .ready_in(r_ready_in),
    .valid_weight_in(valid_weight_in), .weight_in(weight_in), .weight_reload(weight_reload),
    .weights_ready(r_weights_ready), .pxl_out(r_pxl_out), .valid_out(r_valid_out),
    .ch_out_idx(r_ch_out_idx), .frame_done(r_frame_done));

  typedef struct {
    logic [15:0] val;
    logic        ch;
    logic        fd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_assert = 0;
  int n_fail   = 0;
  int push_loc = 0;
  logic signed [15:0] cur_w [8];
  logic [15:0] w [8];
  logic [15:0] px [4];
  int n, fw, seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model(input int k, input logic [15:0] p [4]);
    longint acc = 0;
    for (int i = 0; i < 4; i++)
      acc += longint'(cur_w[k*4+i]) * longint'($signed(p[i]));
    acc = (acc + 128) >>> 8;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic load_weights(input logic [15:0] wv [8]);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) check("ready_in_wload", 32'(ready_in), 0);
      if (j == 7) check("wr_before_last", 32'(weights_ready), 0);
      valid_weight_in = 1'b1;
      weight_in       = wv[j];
      cur_w[j]        = wv[j];
    end
    @(negedge clk);
    valid_weight_in = 1'b0;
    check("wr_after_last", 32'(weights_ready), 1);
  endtask

  task automatic send_loc(input logic [15:0] p [4], input bit hold, output int first_wait);
    exp_t e;
    int wt;
    first_wait = 0;
    for (int k = 0; k < 2; k++) begin
      e.val = model(k, p);
      e.ch  = k[0];
      e.fd  = (k == 1) && (push_loc == 3);
      sb.push_back(e);
    end
    push_loc = (push_loc + 1) % 4;
    for (int j = 0; j < 4; j++) begin
      valid_in = 1'b1;
      pxl_in   = p[j];
      wt = 0;
      while (!ready_in && wt < 200) begin
        @(negedge clk);
        wt++;
      end
      if (wt >= 200) check("ready_timeout", 32'(ready_in), 1);
      if (j == 0) first_wait = wt;
      @(negedge clk);
    end
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic wait_next(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!valid_out && cnt < 100);
  endtask

  task automatic reload();
    weight_reload = 1'b1;
    @(negedge clk);
    weight_reload = 1'b0;
    check("reload_wr", 32'(weights_ready), 0);
    check("reload_ready_in", 32'(ready_in), 0);
  endtask

  task automatic rand_px();
    for (int j = 0; j < 4; j++) px[j] = 16'($urandom_range(0, 65535));
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; valid_weight_in = 1'b0; weight_reload = 1'b0;
    pxl_in = '0; weight_in = '0;
    #2 reset = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (valid_out) begin
          if (sb.size() == 0) begin
            check("unexpected_valid_out", 32'(valid_out), 0);
          end else begin
            mon_e = sb.pop_front();
            check("pxl_out", 32'(pxl_out), 32'(mon_e.val));
            check("ch_out_idx", 32'(ch_out_idx), 32'(mon_e.ch));
            check("frame_done", 32'(frame_done), 32'(mon_e.fd));
            check("relu_valid_out", 32'(r_valid_out), 1);
            check("relu_pxl_out", 32'(r_pxl_out), mon_e.val[15] ? 32'h0 : 32'(mon_e.val));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_pxl_out", 32'(pxl_out), 0);
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_ch_out_idx", 32'(ch_out_idx), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_weights_ready", 32'(weights_ready), 0);
    check("rst_ready_in", 32'(ready_in), 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic dot product and latency
    w = '{8{16'h0100}};
    load_weights(w);
    px = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_loc(px, 1'b0, fw);
    wait_next(n);
    check("first_out_latency", 32'(n), 6);
    wait_next(n);
    check("channel_spacing", 32'(n), 4);
    @(negedge clk);
    check("hold_valid_out", 32'(valid_out), 0);
    check("hold_pxl_out", 32'(pxl_out), 32'h0A00);
    check("hold_ch_out_idx", 32'(ch_out_idx), 1);
    reload();

    // Positive saturation
    w = '{8{16'h7FFF}};
    load_weights(w);
    px = '{4{16'h7FFF}};
    send_loc(px, 1'b0, fw);
    repeat (14) @(negedge clk);
    reload();

    // Negative saturation
    w = '{8{16'h8000}};
    load_weights(w);
    send_loc(px, 1'b0, fw);
    repeat (14) @(negedge clk);
    reload();

    // Negative result (ReLU instance clamps)
    w = '{8{16'hFF00}};
    load_weights(w);
    px = '{4{16'h0100}};
    send_loc(px, 1'b0, fw);
    repeat (14) @(negedge clk);
    reload();

    // Rounding half up
    w = '{16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h007F, 16'h0000, 16'h0000, 16'h0000};
    load_weights(w);
    px = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    send_loc(px, 1'b0, fw);
    repeat (14) @(negedge clk);
    reload();
    w = '{16'hFF80, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000};
    load_weights(w);
    send_loc(px, 1'b0, fw);
    repeat (14) @(negedge clk);

    // Reset in the middle of COMPUTE
    rand_px();
    send_loc(px, 1'b0, fw);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sb.delete();
    push_loc = 0;
    check("midrst_valid_out", 32'(valid_out), 0);
    check("midrst_weights_ready", 32'(weights_ready), 0);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    check("no_valid_out_after_reset", 32'(seen), 0);
    check("wload_after_reset", 32'(ready_in), 0);

    // Full frame with valid_in held high, then first location of the next frame
    for (int j = 0; j < 8; j++) w[j] = 16'($urandom_range(0, 65535));
    load_weights(w);
    for (int l = 0; l < 5; l++) begin
      rand_px();
      send_loc(px, 1'b1, fw);
      if (l > 0) check("ready_low_cycles", 32'(fw), 8);
    end
    weight_reload   = 1'b1;
    valid_weight_in = 1'b1;
    weight_in       = 16'h1234;
    @(negedge clk);
    weight_reload   = 1'b0;
    valid_weight_in = 1'b0;
    valid_in        = 1'b0;
    check("reload_in_compute_ignored", 32'(weights_ready), 1);
    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
